// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 4-stage pipelined FP add/sub with valid/ready flow control
// Truncating arithmetic, no denormals; exp==0 operands are zero.
module fp_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 24,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sub,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    ovf,
  output logic                    unf
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int M_W = FRAC_W + 1;
  localparam logic signed [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // S1: effective signs, zero masking, magnitude ordering
  logic [EXP_W+FRAC_W-1:0] mag_a, mag_b;
  logic                    sign_b, swap;
  always_comb begin
    mag_a  = (a[W-2:FRAC_W] == '0) ? '0 : a[W-2:0];
    mag_b  = (b[W-2:FRAC_W] == '0) ? '0 : b[W-2:0];
    sign_b = b[W-1] ^ in_sub;
    swap   = mag_b > mag_a;
  end

  logic                    s1_valid, s1_sign_l, s1_sign_s;
  logic [TAG_W-1:0]        s1_tag;
  logic [EXP_W+FRAC_W-1:0] s1_mag_l, s1_mag_s;
  logic [EXP_W-1:0]        s1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_tag <= '0; s1_sign_l <= 1'b0; s1_sign_s <= 1'b0;
      s1_mag_l <= '0; s1_mag_s <= '0; s1_d <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_tag    <= in_tag;
      s1_sign_l <= swap ? sign_b : a[W-1];
      s1_sign_s <= swap ? a[W-1] : sign_b;
      s1_mag_l  <= swap ? mag_b : mag_a;
      s1_mag_s  <= swap ? mag_a : mag_b;
      s1_d      <= swap ? (mag_b[W-2:FRAC_W] - mag_a[W-2:FRAC_W])
                        : (mag_a[W-2:FRAC_W] - mag_b[W-2:FRAC_W]);
    end
  end

  // S2: restore hidden bit and align the smaller mantissa
  logic [M_W-1:0] m_l, m_s_full, m_s;
  always_comb begin
    m_l      = {|s1_mag_l[W-2:FRAC_W], s1_mag_l[FRAC_W-1:0]};
    m_s_full = {|s1_mag_s[W-2:FRAC_W], s1_mag_s[FRAC_W-1:0]};
    m_s      = (s1_d >= EXP_W'(M_W)) ? '0 : (m_s_full >> s1_d);
  end

  logic             s2_valid, s2_sign, s2_eff_sub;
  logic [TAG_W-1:0] s2_tag;
  logic [EXP_W-1:0] s2_exp;
  logic [M_W-1:0]   s2_m_l, s2_m_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0; s2_tag <= '0; s2_sign <= 1'b0; s2_eff_sub <= 1'b0;
      s2_exp <= '0; s2_m_l <= '0; s2_m_s <= '0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_tag     <= s1_tag;
      s2_sign    <= s1_sign_l;
      s2_eff_sub <= s1_sign_l ^ s1_sign_s;
      s2_exp     <= s1_mag_l[W-2:FRAC_W];
      s2_m_l     <= m_l;
      s2_m_s     <= m_s;
    end
  end

  // S3: magnitude add or subtract; ordering keeps the difference non-negative
  logic             s3_valid, s3_sign;
  logic [TAG_W-1:0] s3_tag;
  logic [EXP_W-1:0] s3_exp;
  logic [M_W:0]     s3_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0; s3_tag <= '0; s3_sign <= 1'b0; s3_exp <= '0; s3_sum <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_tag   <= s2_tag;
      s3_sign  <= s2_sign;
      s3_exp   <= s2_exp;
      s3_sum   <= s2_eff_sub ? ({1'b0, s2_m_l} - {1'b0, s2_m_s})
                             : ({1'b0, s2_m_l} + {1'b0, s2_m_s});
    end
  end

  // S4: normalize, then saturate or flush on exponent range
  logic [EXP_W+1:0]        lzc;
  logic signed [EXP_W+1:0] n_exp;
  logic [M_W-1:0]          shifted;
  logic [FRAC_W-1:0]       n_frac;
  logic [W-1:0]            r_word;
  logic                    r_ovf, r_unf;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < M_W; i++) begin
      if (s3_sum[i]) lzc = (EXP_W+2)'(FRAC_W - i);
    end
    shifted = s3_sum[M_W-1:0] << lzc;
    if (s3_sum[M_W]) begin
      n_exp  = $signed({2'b00, s3_exp} + 1'b1);
      n_frac = s3_sum[FRAC_W:1];
    end else begin
      n_exp  = $signed({2'b00, s3_exp} - lzc);
      n_frac = shifted[FRAC_W-1:0];
    end
    r_word = {s3_sign, n_exp[EXP_W-1:0], n_frac};
    r_ovf  = 1'b0;
    r_unf  = 1'b0;
    if (s3_sum == '0) begin
      r_word = '0;
    end else if (n_exp >= EXP_MAX) begin
      r_word = {s3_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      r_ovf  = 1'b1;
    end else if (n_exp <= EXP_ZERO) begin
      r_word = '0;
      r_unf  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0; out_tag <= '0; result <= '0; ovf <= 1'b0; unf <= 1'b0;
    end else if (adv) begin
      out_valid <= s3_valid;
      out_tag   <= s3_tag;
      result    <= r_word;
      ovf       <= r_ovf;
      unf       <= r_unf;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - scoreboard bench for fp_addsub_pipe
// Driver pushes expected {tag,ovf,unf,result}; monitor pops on each output transfer.
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready, ovf, unf;
  logic [3:0]  in_tag, out_tag;
  logic [32:0] a, b, result;

  int n_total = 0;
  int n_pass  = 0;
  int n_mon   = 0;
  logic [38:0] exp_q[$];

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .FRAC_W(24), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_tag(in_tag), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .result(result), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Directed vectors: a, b, sub, expected result, ovf, unf
  localparam int NV = 11;
  logic [32:0] va [NV] = '{33'h07F000000, 33'h07F800000, 33'h07F800000, 33'h07F000000,
                           33'h000000000, 33'h0FEFFFFFF, 33'h07F000000, 33'h080000000,
                           33'h07F000000, 33'h001000000, 33'h000123456};
  logic [32:0] vb [NV] = '{33'h080000000, 33'h17E000000, 33'h07E000000, 33'h07F000000,
                           33'h000000000, 33'h0FEFFFFFF, 33'h064000000, 33'h07F000000,
                           33'h080000000, 33'h001800000, 33'h07F000000};
  logic        vs [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [32:0] vr [NV] = '{33'h080800000, 33'h07F000000, 33'h07F000000, 33'h000000000,
                           33'h000000000, 33'h0FF000000, 33'h07F000000, 33'h07F000000,
                           33'h17F000000, 33'h000000000, 33'h07F000000};
  logic        vo [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        vu [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int idx, input logic [3:0] tag);
    int waitc = 0;
    a = va[idx]; b = vb[idx]; in_sub = vs[idx]; in_tag = tag; in_valid = 1'b1;
    #1;
    while (!in_ready && waitc < 50) begin
      @(negedge clk); #1; waitc++;
    end
    if (!in_ready) $display("FAIL send_timeout: got in_ready %b expected 1", in_ready);
    else exp_q.push_back({tag, vo[idx], vu[idx], vr[idx]});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waitc = 0;
    while (exp_q.size() != 0 && waitc < 200) begin
      @(negedge clk); waitc++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk); #2;
      if (out_valid && out_ready && !rst) begin
        n_mon++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {25'd0, out_tag, ovf, unf, result}, 64'd0);
        end else begin
          chk($sformatf("out_tag%0d", out_tag), {25'd0, out_tag, ovf, unf, result},
              {25'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin : stimulus
    int lat;
    int mon_before;
    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_tag = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'd0, out_valid, out_tag, ovf, unf, result}, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Latency on the first vector
    send(0, 4'd3);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    drain();

    for (int i = 1; i < NV; i++) send(i, 4'(i + 3));
    drain();

    // Back-to-back stream of 8 with a 3-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, 4'(i));
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk($sformatf("stall_in_ready_c%0d", k + 6), 64'(in_ready), 64'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(n_mon), 64'(1 + (NV - 1) + 8));

    // Reset with three operations in flight
    send(1, 4'd8);
    send(2, 4'd9);
    send(3, 4'd10);
    rst = 1'b1;
    exp_q.delete();
    mon_before = n_mon;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_outputs", 64'(n_mon - mon_before), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
